// File: rtl/shared_buff_pop_arb.sv
// Credit-gated round-robin pop arbiter for a shared multi-queue buffer, with a one-word output register.
// Optional per-queue pop statistics are compiled in when SHARED_BUFF_POP_ARB_STATS_EN is defined.
module shared_buff_pop_arb #(
  parameter int DW   = 16,
  parameter int Q    = 4,
  parameter int CRED = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [Q-1:0]  buf_valid_i,
  input  logic [DW-1:0] buf_data_i,
  output logic [Q-1:0]  buf_pop_sel_o,
  output logic          buf_pop_o,
  output logic          out_valid_o,
  output logic [DW-1:0] out_data_o,
  output logic [Q-1:0]  out_qid_o,
  input  logic          out_ready_i,
  input  logic [Q-1:0]  credit_ret_i
`ifdef SHARED_BUFF_POP_ARB_STATS_EN
  ,
  input  logic              stat_clr_i,
  output logic [Q-1:0][15:0] stat_cnt_o
`endif
);

  localparam int CW = $clog2(CRED + 1);
  localparam int IW = (Q > 1) ? $clog2(Q) : 1;

  logic [Q-1:0]  eligible;
  logic [Q-1:0]  grant_oh;
  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [IW-1:0] grant_idx;
  logic          load_ok;

  assign load_ok   = !out_valid_o || out_ready_i;
  assign buf_pop_o = !rst && load_ok && (|eligible);

  // Scan eligible queues starting at the pointer; first hit wins.
  always_comb begin
    logic found;
    int   idx;
    found     = 1'b0;
    idx       = 0;
    grant_idx = '0;
    for (int k = 0; k < Q; k++) begin
      idx = (int'(ptr_reg) + k) % Q;
      if (!found && eligible[idx]) begin
        found     = 1'b1;
        grant_idx = IW'(idx);
      end
    end
  end

  assign grant_oh      = Q'(1) << grant_idx;
  assign buf_pop_sel_o = buf_pop_o ? grant_oh : '0;

  always_comb begin
    ptr_next = grant_idx + IW'(1);
    if (int'(grant_idx) == Q - 1) ptr_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (buf_pop_o) begin
      ptr_reg <= ptr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_o <= 1'b0;
      out_qid_o   <= '0;
    end else if (buf_pop_o) begin
      out_valid_o <= 1'b1;
      out_qid_o   <= grant_oh;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  // Data path is intentionally left out of reset.
  always_ff @(posedge clk) begin
    if (buf_pop_o) out_data_o <= buf_data_i;
  end

  genvar gi;
  generate
    for (gi = 0; gi < Q; gi++) begin : g_queue
      logic [CW-1:0] cred_reg;
      logic          pop_q;

      assign pop_q        = buf_pop_o && grant_oh[gi];
      assign eligible[gi] = buf_valid_i[gi] && (cred_reg != '0);

      // Simultaneous pop and return cancel out; a returned credit is only visible next cycle.
      always_ff @(posedge clk) begin
        if (rst) begin
          cred_reg <= CW'(CRED);
        end else if (pop_q && !credit_ret_i[gi]) begin
          cred_reg <= cred_reg - CW'(1);
        end else if (!pop_q && credit_ret_i[gi] && (cred_reg != CW'(CRED))) begin
          cred_reg <= cred_reg + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!rst && credit_ret_i[gi] && !pop_q) begin
          assert (cred_reg != CW'(CRED));
        end
      end

`ifdef SHARED_BUFF_POP_ARB_STATS_EN
      always_ff @(posedge clk) begin
        if (rst || stat_clr_i) begin
          stat_cnt_o[gi] <= '0;
        end else if (pop_q && (stat_cnt_o[gi] != 16'hFFFF)) begin
          stat_cnt_o[gi] <= stat_cnt_o[gi] + 16'd1;
        end
      end
`endif
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(buf_pop_sel_o));
      assert (!buf_pop_o || ((buf_pop_sel_o & buf_valid_i) != '0));
    end
  end

endmodule

// File: tb/tb_shared_buff_pop_arb.sv
// Scoreboard bench for shared_buff_pop_arb: a behavioural arbiter/credit model predicts every pop
// and output word; stats checks are compiled when SHARED_BUFF_POP_ARB_STATS_EN is defined.
module tb_shared_buff_pop_arb;
  localparam int DW   = 16;
  localparam int Q    = 4;
  localparam int CRED = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [Q-1:0]  buf_valid_i;
  logic [DW-1:0] buf_data_i;
  logic [Q-1:0]  buf_pop_sel_o;
  logic          buf_pop_o;
  logic          out_valid_o;
  logic [DW-1:0] out_data_o;
  logic [Q-1:0]  out_qid_o;
  logic          out_ready_i;
  logic [Q-1:0]  credit_ret_i;
`ifdef SHARED_BUFF_POP_ARB_STATS_EN
  logic               stat_clr_i;
  logic [Q-1:0][15:0] stat_cnt_o;
`endif

  shared_buff_pop_arb #(.DW(DW), .Q(Q), .CRED(CRED)) dut (
    .clk(clk),
    .rst(rst),
    .buf_valid_i(buf_valid_i),
    .buf_data_i(buf_data_i),
    .buf_pop_sel_o(buf_pop_sel_o),
    .buf_pop_o(buf_pop_o),
    .out_valid_o(out_valid_o),
    .out_data_o(out_data_o),
    .out_qid_o(out_qid_o),
    .out_ready_i(out_ready_i),
    .credit_ret_i(credit_ret_i)
`ifdef SHARED_BUFF_POP_ARB_STATS_EN
    ,
    .stat_clr_i(stat_clr_i),
    .stat_cnt_o(stat_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [Q-1:0]  qid;
    logic [DW-1:0] data;
  } word_t;

  int            total = 0;
  int            bad   = 0;
  int            m_cred [Q];
  int            m_ptr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [Q-1:0]  m_qid;
  word_t         sb [$];
  logic [DW-1:0] next_data;
  int            dut_pops;

  // One arbiter cycle, entered and left just after a falling edge.
  task automatic cycle(input logic [Q-1:0] valid, input logic ready, input logic [Q-1:0] ret);
    logic [Q-1:0] elig;
    logic [Q-1:0] exp_sel;
    logic         exp_pop;
    int           g;
    word_t        w;
    buf_valid_i  = valid;
    out_ready_i  = ready;
    credit_ret_i = ret;
    buf_data_i   = next_data;
    for (int q = 0; q < Q; q++) elig[q] = valid[q] && (m_cred[q] > 0);
    exp_pop = (!m_valid || ready) && (elig != '0);
    g = -1;
    for (int k = 0; k < Q; k++) if (g < 0 && elig[(m_ptr + k) % Q]) g = (m_ptr + k) % Q;
    exp_sel = '0;
    if (exp_pop) exp_sel[g] = 1'b1;
    #1;
    total += 2;
    if (buf_pop_o !== exp_pop) begin
      bad++;
      $display("FAIL pop: got %b want %b", buf_pop_o, exp_pop);
    end
    if (buf_pop_sel_o !== exp_sel) begin
      bad++;
      $display("FAIL pop_sel: got %b want %b", buf_pop_sel_o, exp_sel);
    end
    if (buf_pop_o === 1'b1) dut_pops++;
    if (exp_pop) sb.push_back({exp_sel, next_data});
    @(posedge clk);
    for (int q = 0; q < Q; q++) begin
      if (exp_pop && g == q && !ret[q]) m_cred[q]--;
      else if (!(exp_pop && g == q) && ret[q] && m_cred[q] < CRED) m_cred[q]++;
    end
    if (exp_pop) begin
      m_ptr   = (g + 1) % Q;
      m_valid = 1'b1;
    end else if (ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    if (exp_pop) begin
      w      = sb.pop_front();
      m_data = w.data;
      m_qid  = w.qid;
    end
    total++;
    if (out_valid_o !== m_valid) begin
      bad++;
      $display("FAIL out_valid: got %b want %b", out_valid_o, m_valid);
    end
    if (m_valid) begin
      total += 2;
      if (out_data_o !== m_data) begin
        bad++;
        $display("FAIL out_data: got %h want %h", out_data_o, m_data);
      end
      if (out_qid_o !== m_qid) begin
        bad++;
        $display("FAIL out_qid: got %b want %b", out_qid_o, m_qid);
      end
    end
    if (exp_pop) $display("word: qid=%b data=%h ready=%b", m_qid, m_data, ready);
    next_data = DW'($urandom);
  endtask

  task automatic do_reset(input logic [Q-1:0] valid);
    rst          = 1'b1;
    buf_valid_i  = valid;
    out_ready_i  = 1'b0;
    credit_ret_i = '0;
    buf_data_i   = next_data;
    #1;
    total += 2;
    if (buf_pop_o !== 1'b0) begin
      bad++;
      $display("FAIL pop_in_reset: got %b want 0", buf_pop_o);
    end
    if (buf_pop_sel_o !== '0) begin
      bad++;
      $display("FAIL sel_in_reset: got %b want 0", buf_pop_sel_o);
    end
    @(posedge clk);
    m_valid = 1'b0;
    m_ptr   = 0;
    m_qid   = '0;
    for (int q = 0; q < Q; q++) m_cred[q] = CRED;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    total += 2;
    if (out_valid_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b want 0", out_valid_o);
    end
    if (out_qid_o !== '0) begin
      bad++;
      $display("FAIL reset_qid: got %b want 0", out_qid_o);
    end
    $display("reset done");
  endtask

  task automatic test_reset();
    do_reset(4'b1111);
  endtask

  task automatic test_round_robin();
    logic [Q-1:0] prev;
    logic [Q-1:0] want;
    do_reset(4'b0000);
    prev = '0;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1111, 1'b1, prev);
      want = 4'b0001 << (i % Q);
      total++;
      if (out_qid_o !== want) begin
        bad++;
        $display("FAIL rr_order[%0d]: got %b want %b", i, out_qid_o, want);
      end
      prev = want;
    end
  endtask

  task automatic test_credit_limit();
    do_reset(4'b0000);
    dut_pops = 0;
    repeat (4) cycle(4'b0100, 1'b1, 4'b0000);
    total++;
    if (dut_pops != 2) begin
      bad++;
      $display("FAIL credit_limit: got %0d pops want 2", dut_pops);
    end
    cycle(4'b0100, 1'b1, 4'b0100);
    total++;
    if (dut_pops != 2) begin
      bad++;
      $display("FAIL credit_same_cycle: got %0d pops want 2", dut_pops);
    end
    repeat (3) cycle(4'b0100, 1'b1, 4'b0000);
    total++;
    if (dut_pops != 3) begin
      bad++;
      $display("FAIL credit_return: got %0d pops want 3", dut_pops);
    end
  endtask

  task automatic test_backpressure();
    do_reset(4'b0000);
    next_data = 16'hA5A5;
    cycle(4'b0001, 1'b0, 4'b0000);
    dut_pops = 0;
    repeat (10) cycle(4'b1111, 1'b0, 4'b0000);
    total += 2;
    if (dut_pops != 0) begin
      bad++;
      $display("FAIL stall_pops: got %0d want 0", dut_pops);
    end
    if (out_data_o !== 16'hA5A5) begin
      bad++;
      $display("FAIL stall_data: got %h want a5a5", out_data_o);
    end
    cycle(4'b1111, 1'b1, 4'b0000);
    total++;
    if (out_qid_o !== 4'b0010) begin
      bad++;
      $display("FAIL release_qid: got %b want 0010", out_qid_o);
    end
  endtask

  task automatic test_pop_and_return();
    do_reset(4'b0000);
    dut_pops = 0;
    cycle(4'b0010, 1'b1, 4'b0000);
    cycle(4'b0010, 1'b1, 4'b0010);
    repeat (3) cycle(4'b0010, 1'b1, 4'b0000);
    total++;
    if (dut_pops != 3) begin
      bad++;
      $display("FAIL pop_ret_same_cycle: got %0d pops want 3", dut_pops);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset(4'b0000);
    cycle(4'b1111, 1'b0, 4'b0000);
    cycle(4'b0100, 1'b0, 4'b0000);
    do_reset(4'b1111);
    dut_pops = 0;
    cycle(4'b1111, 1'b1, 4'b0000);
    total++;
    if (out_qid_o !== 4'b0001) begin
      bad++;
      $display("FAIL first_grant: got %b want 0001", out_qid_o);
    end
    repeat (3) cycle(4'b0001, 1'b1, 4'b0000);
    total++;
    if (dut_pops != 2) begin
      bad++;
      $display("FAIL credits_restored: got %0d pops want 2", dut_pops);
    end
  endtask

`ifdef SHARED_BUFF_POP_ARB_STATS_EN
  task automatic test_stats();
    do_reset(4'b0000);
    total++;
    if (stat_cnt_o !== '0) begin
      bad++;
      $display("FAIL stat_reset: got %h want 0", stat_cnt_o);
    end
    buf_valid_i  = 4'b1000;
    out_ready_i  = 1'b1;
    credit_ret_i = 4'b1000;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    buf_valid_i  = '0;
    credit_ret_i = '0;
    total += 2;
    if (stat_cnt_o[3] !== 16'hFFFF) begin
      bad++;
      $display("FAIL stat_saturate: got %h want ffff", stat_cnt_o[3]);
    end
    if (stat_cnt_o[0] !== 16'h0000) begin
      bad++;
      $display("FAIL stat_idle_queue: got %h want 0000", stat_cnt_o[0]);
    end
    stat_clr_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    stat_clr_i = 1'b0;
    total++;
    if (stat_cnt_o[3] !== 16'h0000) begin
      bad++;
      $display("FAIL stat_clear: got %h want 0000", stat_cnt_o[3]);
    end
    $display("stats: 70000 pops on queue 3 then clear");
  endtask
`endif

  initial begin
    next_data = 16'h1234;
    dut_pops  = 0;
    m_valid   = 1'b0;
    m_ptr     = 0;
    m_data    = '0;
    m_qid     = '0;
`ifdef SHARED_BUFF_POP_ARB_STATS_EN
    stat_clr_i = 1'b0;
`endif
    test_reset();
    test_round_robin();
    test_credit_limit();
    test_backpressure();
    test_pop_and_return();
    test_reset_midflight();
`ifdef SHARED_BUFF_POP_ARB_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
